batchnorm_seq: RTL and testbench

BATCHNORM_SEQ -- requirements
Module: batchnorm_seq

---
 rtl/batchnorm_seq.sv | 143 ++++++++++++++
 tb/tb_batchnorm_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batchnorm_seq.sv
// Sequential batch-normalisation: y = round(x*scale + bias) per channel, LANES
// channels per cycle, saturating to WIDTH bits with optional ReLU.
module batchnorm_seq #(
  parameter int WIDTH   = 16,
  parameter int NFRAC   = 10,
  parameter int NUM_CH  = 16,
  parameter int LANES   = 4,
  parameter int RELU_EN = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           input_ready,
  input  logic [NUM_CH-1:0][WIDTH-1:0]   input_data,
  input  logic [NUM_CH-1:0][WIDTH-1:0]   scale,
  input  logic [NUM_CH-1:0][WIDTH-1:0]   bias,
  output logic                           busy,
  output logic                           output_ready,
  output logic [NUM_CH-1:0][WIDTH-1:0]   output_data,
  output logic                           sat_flag
);

  localparam int PASSES = (NUM_CH + LANES - 1) / LANES;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  // two guard bits keep product + shifted bias + rounding constant exact
  localparam int ACC    = 2 * WIDTH + 2;
  localparam logic signed [ACC-1:0] MAX_V = ACC'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [ACC-1:0] MIN_V = ACC'($signed({1'b1, {(WIDTH-1){1'b0}}}));
  localparam logic signed [ACC-1:0] RND   = ACC'(1'b1) <<< (NFRAC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                         state;
  logic [PW-1:0]                  pass_cnt;
  logic [NUM_CH-1:0][WIDTH-1:0]   x_r;
  logic [NUM_CH-1:0][WIDTH-1:0]   s_r;
  logic [NUM_CH-1:0][WIDTH-1:0]   b_r;
  logic [LANES-1:0][WIDTH-1:0]    lane_x;
  logic [LANES-1:0][WIDTH-1:0]    lane_s;
  logic [LANES-1:0][WIDTH-1:0]    lane_b;
  logic [LANES-1:0][WIDTH:0]      lane_res;
  logic                           lane_sat;

  // Returns {saturated, result}; floor after adding half gives round-half-up.
  function automatic logic [WIDTH:0] bn_lane(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] s,
                                             input logic [WIDTH-1:0] b);
    logic signed [ACC-1:0] acc;
    logic signed [ACC-1:0] rnd;
    logic [WIDTH-1:0]      y;
    logic                  sat;
    acc = ACC'($signed(x)) * ACC'($signed(s));
    acc = acc + (ACC'($signed(b)) <<< NFRAC) + RND;
    rnd = acc >>> NFRAC;
    if (rnd > MAX_V) begin
      y   = MAX_V[WIDTH-1:0];
      sat = 1'b1;
    end else if (rnd < MIN_V) begin
      y   = MIN_V[WIDTH-1:0];
      sat = 1'b1;
    end else begin
      y   = rnd[WIDTH-1:0];
      sat = 1'b0;
    end
    y = ((RELU_EN != 0) && y[WIDTH-1]) ? '0 : y;
    return {sat, y};
  endfunction

  // Route the channels of the current pass onto the lanes; idle lanes see zero.
  always_comb begin
    lane_x = '0;
    lane_s = '0;
    lane_b = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      lane_x[c % LANES] = (c / LANES == int'(pass_cnt)) ? x_r[c] : lane_x[c % LANES];
      lane_s[c % LANES] = (c / LANES == int'(pass_cnt)) ? s_r[c] : lane_s[c % LANES];
      lane_b[c % LANES] = (c / LANES == int'(pass_cnt)) ? b_r[c] : lane_b[c % LANES];
    end
  end

  // Per-lane arithmetic and saturation summary for this pass.
  always_comb begin
    lane_res = '0;
    lane_sat = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_res[l] = bn_lane(lane_x[l], lane_s[l], lane_b[l]);
      lane_sat    = lane_sat | lane_res[l][WIDTH];
    end
  end

  // Control FSM with registered outputs and per-pass result write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pass_cnt     <= '0;
      busy         <= 1'b0;
      output_ready <= 1'b0;
      sat_flag     <= 1'b0;
      output_data  <= '0;
      x_r          <= '0;
      s_r          <= '0;
      b_r          <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (input_ready) begin
            x_r          <= input_data;
            s_r          <= scale;
            b_r          <= bias;
            output_ready <= 1'b0;
            sat_flag     <= 1'b0;
            pass_cnt     <= '0;
            busy         <= 1'b1;
            state        <= COMPUTE;
          end
        end
        COMPUTE: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (c / LANES == int'(pass_cnt)) begin
              output_data[c] <= lane_res[c % LANES][WIDTH-1:0];
            end
          end
          sat_flag <= sat_flag | lane_sat;
          if (pass_cnt == PW'(PASSES - 1)) begin
            pass_cnt     <= '0;
            busy         <= 1'b0;
            output_ready <= 1'b1;
            state        <= DONE;
          end else begin
            pass_cnt <= pass_cnt + PW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_batchnorm_seq.sv
// Testbench for batchnorm_seq: table vectors and random vectors through a
// scoreboard on the default instance, plus partial-pass and ReLU instances.
module tb_batchnorm_seq;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic                 in_rdy;
  logic [15:0][15:0]    in_data, sc, bi, out_data;
  logic                 busy, out_rdy, sat;

  logic                 r1_in_rdy;
  logic [4:0][15:0]     r1_in, r1_sc, r1_bi, r1_out;
  logic                 r1_busy, r1_rdy, r1_sat;

  logic                 r2_in_rdy;
  logic [15:0][15:0]    r2_in, r2_sc, r2_bi, r2_out;
  logic                 r2_busy, r2_rdy, r2_sat;

  batchnorm_seq u0 (
    .clk(clk), .reset(reset), .input_ready(in_rdy), .input_data(in_data),
    .scale(sc), .bias(bi), .busy(busy), .output_ready(out_rdy),
    .output_data(out_data), .sat_flag(sat));

  batchnorm_seq #(.NUM_CH(5), .LANES(2)) u1 (
    .clk(clk), .reset(reset), .input_ready(r1_in_rdy), .input_data(r1_in),
    .scale(r1_sc), .bias(r1_bi), .busy(r1_busy), .output_ready(r1_rdy),
    .output_data(r1_out), .sat_flag(r1_sat));

  batchnorm_seq #(.RELU_EN(1)) u2 (
    .clk(clk), .reset(reset), .input_ready(r2_in_rdy), .input_data(r2_in),
    .scale(r2_sc), .bias(r2_bi), .busy(r2_busy), .output_ready(r2_rdy),
    .output_data(r2_out), .sat_flag(r2_sat));

  typedef struct {
    logic [15:0] x, s, b, y;
    logic        sat;
  } row_t;

  typedef struct {
    logic [15:0][15:0] data;
    logic              sat;
    int                due;
  } exp_t;

  row_t  tbl [16];
  exp_t  sb [$];
  exp_t  last_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: exact integer arithmetic with floor division.
  function automatic logic [16:0] ref_bn(input int x, input int s, input int b);
    longint p, q;
    logic   st;
    p = longint'(x) * longint'(s) + longint'(b) * 1024 + 512;
    q = p / 1024;
    if (p < 0 && (p % 1024) != 0) q = q - 1;
    st = 1'b0;
    if (q > 32767) begin q = 32767; st = 1'b1; end
    else if (q < -32768) begin q = -32768; st = 1'b1; end
    return {st, 16'(q)};
  endfunction

  task automatic set_row(input int i, input int x, input int s, input int b, input int y, input logic st);
    tbl[i] = '{16'(x), 16'(s), 16'(b), 16'(y), st};
  endtask

  task automatic start_vec(input logic [15:0][15:0] x, input logic [15:0][15:0] s,
                           input logic [15:0][15:0] b, input logic [15:0][15:0] ey,
                           input logic es, input int hold);
    @(negedge clk);
    in_data = x; sc = s; bi = b; in_rdy = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{ey, es, cyc + 4});
    repeat (hold) @(posedge clk);
    @(negedge clk);
    in_rdy = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    chk({name, "_drained"}, sb.size(), 0);
  endtask

  task automatic rand_vec(output logic [15:0][15:0] x, output logic [15:0][15:0] s,
                          output logic [15:0][15:0] b, output logic [15:0][15:0] ey,
                          output logic es);
    logic [16:0] r;
    es = 1'b0;
    for (int c = 0; c < 16; c++) begin
      x[c] = 16'($urandom);
      s[c] = 16'($urandom_range(0, 4095)) - 16'd2048;
      b[c] = 16'($urandom_range(0, 8191)) - 16'd4096;
      r = ref_bn(int'($signed(x[c])), int'($signed(s[c])), int'($signed(b[c])));
      ey[c] = r[15:0];
      es = es | r[16];
    end
  endtask

  task automatic run_u1(input int base);
    logic [4:0][15:0] ey;
    logic es;
    int t0;
    es = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      r1_in[c] = tbl[base + c].x; r1_sc[c] = tbl[base + c].s; r1_bi[c] = tbl[base + c].b;
      ey[c] = tbl[base + c].y;
      es = es | tbl[base + c].sat;
    end
    r1_in_rdy = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    chk("u1_busy", int'(r1_busy), 1);
    @(negedge clk);
    r1_in_rdy = 1'b0;
    do begin @(posedge clk); #1; end while (!r1_rdy && (cyc - t0) < 12);
    chk("u1_latency", cyc - t0, 3);
    chk_vec("u1_data", 256'(r1_out), 256'(ey));
    chk("u1_sat", int'(r1_sat), int'(es));
  endtask

  task automatic run_relu(input int x0, input int s0, input int x1, input int s1,
                          input int y0, input int y1, input int es);
    logic [15:0][15:0] ey;
    int t0;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      r2_in[c] = 16'hFFFF; r2_sc[c] = 16'd1024; r2_bi[c] = 16'd0; ey[c] = 16'd0;
    end
    r2_in[0] = 16'(x0); r2_sc[0] = 16'(s0); ey[0] = 16'(y0);
    r2_in[1] = 16'(x1); r2_sc[1] = 16'(s1); ey[1] = 16'(y1);
    r2_in_rdy = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    chk("relu_busy", int'(r2_busy), 1);
    @(negedge clk);
    r2_in_rdy = 1'b0;
    do begin @(posedge clk); #1; end while (!r2_rdy && (cyc - t0) < 12);
    chk("relu_latency", cyc - t0, 4);
    chk_vec("relu_data", r2_out, ey);
    chk("relu_sat", int'(r2_sat), es);
  endtask

  // Scoreboard monitor for the default instance.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      chk("busy_and_ready", int'(busy & out_rdy), 0);
      if (out_rdy && !prev) begin
        chk("pending_result", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("latency", cyc, e.due);
          chk_vec("data", out_data, e.data);
          chk("sat", int'(sat), int'(e.sat));
          last_exp = e;
        end
      end
      prev = out_rdy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0][15:0] vx, vs, vb, vy;
    logic              vsat;
    int                nosat [$];

    cyc = 0; n_checks = 0; n_fail = 0;
    reset = 1'b0;
    in_rdy = 1'b0; in_data = '0; sc = '0; bi = '0;
    r1_in_rdy = 1'b0; r1_in = '0; r1_sc = '0; r1_bi = '0;
    r2_in_rdy = 1'b0; r2_in = '0; r2_sc = '0; r2_bi = '0;

    set_row(0,    -304, 1024,     0,   -304, 1'b0);
    set_row(1,     378, 1024,     0,    378, 1'b0);
    set_row(2,       3,  512,     0,      2, 1'b0);
    set_row(3,      -3,  512,     0,     -1, 1'b0);
    set_row(4,       1,  512,     0,      1, 1'b0);
    set_row(5,      -1,  512,     0,      0, 1'b0);
    set_row(6,   20000, 2048,     0,  32767, 1'b1);
    set_row(7,  -20000, 2048,     0, -32768, 1'b1);
    set_row(8,       0, 1024,  1024,   1024, 1'b0);
    set_row(9,     100, -1024,    0,   -100, 1'b0);
    set_row(10,      7, 1536,     0,     11, 1'b0);
    set_row(11,     -7, 1536,     0,    -10, 1'b0);
    set_row(12,   1000, 1024, -2048,  -1048, 1'b0);
    set_row(13,  32767, 1024,  1024,  32767, 1'b1);
    set_row(14,      0,    0,    -5,     -5, 1'b0);
    set_row(15,  12345, 1024,     0,  12345, 1'b0);
    for (int i = 0; i < 16; i++) if (!tbl[i].sat) nosat.push_back(i);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(out_rdy), 0);
    chk("rst_sat", int'(sat), 0);
    chk_vec("rst_data", out_data, 256'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table vectors: 0 = non-saturating rows (identity on ch0/ch1), 1 = all rows, 2 = reversed.
    for (int v = 0; v < 3; v++) begin
      vsat = 1'b0;
      for (int c = 0; c < 16; c++) begin
        int r;
        r = (v == 0) ? nosat[c % nosat.size()] : ((v == 1) ? c : 15 - c);
        vx[c] = tbl[r].x; vs[c] = tbl[r].s; vb[c] = tbl[r].b; vy[c] = tbl[r].y;
        vsat = vsat | tbl[r].sat;
      end
      start_vec(vx, vs, vb, vy, vsat, 0);
      wait_done("table");
    end

    // input_ready held through COMPUTE: one computation, normal latency.
    rand_vec(vx, vs, vb, vy, vsat);
    start_vec(vx, vs, vb, vy, vsat, 3);
    wait_done("hold");
    repeat (6) @(posedge clk);
    #1;
    chk("done_ready_level", int'(out_rdy), 1);
    chk("done_no_restart", int'(busy), 0);
    chk_vec("done_data_stable", out_data, last_exp.data);

    // New start from DONE drops output_ready immediately.
    rand_vec(vx, vs, vb, vy, vsat);
    start_vec(vx, vs, vb, vy, vsat, 0);
    chk("restart_ready_low", int'(out_rdy), 0);
    chk("restart_busy", int'(busy), 1);
    wait_done("restart");

    for (int n = 0; n < 3; n++) begin
      rand_vec(vx, vs, vb, vy, vsat);
      start_vec(vx, vs, vb, vy, vsat, 0);
      wait_done("random");
    end

    // Reset during pass 2, then a clean computation afterwards.
    rand_vec(vx, vs, vb, vy, vsat);
    start_vec(vx, vs, vb, vy, vsat, 0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk_vec("abort_data", out_data, 256'd0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(out_rdy), 0);
    chk("abort_sat", int'(sat), 0);
    chk("abort_pending", sb.size(), 1);
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    reset = 1'b1;
    rand_vec(vx, vs, vb, vy, vsat);
    start_vec(vx, vs, vb, vy, vsat, 0);
    wait_done("after_reset");

    run_u1(0);
    run_u1(6);

    run_relu(-304, 1024, 500, 1024, 0, 500, 0);
    run_relu(-20000, 2048, 20000, 2048, 0, 32767, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
